// File: rtl/cc_geom_pkg.sv
// cc_geom_pkg: shared constants and width helpers for the polygon stream engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cc_geom_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Job modes
  localparam logic [1:0] MODE_AREA = 2'd0;
  localparam logic [1:0] MODE_LC   = 2'd1;
  localparam logic [1:0] MODE_BBOX = 2'd2;
  localparam logic [1:0] MODE_CONV = 2'd3;

  // Line-circle result codes
  localparam logic [1:0] RES_NONE      = 2'd0;
  localparam logic [1:0] RES_INTERSECT = 2'd1;
  localparam logic [1:0] RES_TANGENT   = 2'd2;

  // Shoelace accumulator width: doubled-area sum of up to max_vert full-range terms.
  function automatic int acc_w(input int coord_w, input int max_vert);
    return 2 * coord_w + $clog2(max_vert) + 2;
  endfunction

  // Width able to hold a vertex count of 0..max_vert.
  function automatic int cnt_w(input int max_vert);
    return $clog2(max_vert + 1);
  endfunction

endpackage

// File: rtl/cc_cross2.sv
// cc_cross2: signed 2-D cross product / determinant x1*y2 - x2*y1 at full precision.
// Latency: combinational.
// Backpressure: none.
module cc_cross2 #(
  parameter int W = 9
) (
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] y2,
  output logic signed [2*W:0] cr
);

  logic signed [2*W:0] x1_e, y1_e, x2_e, y2_e;

  assign x1_e = (2*W+1)'(x1);
  assign y1_e = (2*W+1)'(y1);
  assign x2_e = (2*W+1)'(x2);
  assign y2_e = (2*W+1)'(y2);
  assign cr   = x1_e * y2_e - x2_e * y1_e;

endmodule

// File: rtl/cc_poly_stream.sv
// cc_poly_stream: streaming area / line-circle / bounding-box / convexity engine, one vertex per cycle.
// Latency: result 2 cycles after the last vertex; bbox gives (min) then (max) on consecutive cycles.
// Backpressure: none; source holds in_valid for exactly the job length and restarts after out_valid falls.
// Build option CC_ORIENT_EN: convexity result also encodes orientation (1 ccw, 2 cw, 0 otherwise).
module cc_poly_stream
  import cc_geom_pkg::*;
#(
  parameter int COORD_W  = 8,
  parameter int MAX_VERT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [1:0]                    mode,
  input  logic [$clog2(MAX_VERT+1)-1:0] n_vert,
  input  logic [COORD_W-1:0]            xi,
  input  logic [COORD_W-1:0]            yi,
  output logic                          out_valid,
  output logic [COORD_W-1:0]            xo,
  output logic [COORD_W-1:0]            yo
);

  localparam int W  = COORD_W;
  localparam int E  = COORD_W + 1;        // coordinate differences need one extra bit
  localparam int CW = 2 * E + 1;          // cross-unit result width
  localparam int NW = cnt_w(MAX_VERT);
  localparam int AW = acc_w(COORD_W, MAX_VERT);
  localparam int LW = 4 * COORD_W + 8;    // holds the squared line distance and scaled radius

  function automatic logic signed [E-1:0] ext(input logic signed [W-1:0] v);
    return E'(v);
  endfunction

  logic [1:0]           state, mode_r;
  logic [NW-1:0]        cnt, last_idx, job_len;
  logic signed [W-1:0]  cur_x, cur_y;
  logic signed [W-1:0]  v0x, v0y, v1x, v1y, p1x, p1y, p2x, p2y;
  logic signed [W-1:0]  xmin, ymin, xmax, ymax;
  logic signed [AW-1:0] acc, acc_fin, acc_abs;
  logic                 has_pos, has_neg, out_ph;
  logic signed [E-1:0]  ca_x1, ca_y1, ca_x2, ca_y2, cb_x1, cb_y1, cb_x2, cb_y2;
  logic signed [CW-1:0] ca_cr, cb_cr;
  logic                 ca_pos, ca_neg, cb_pos, cb_neg, pos_f, neg_f;
  logic [2*W-1:0]       area;
  logic                 unused_area;
  logic signed [LW-1:0] la, lb, lcc, lin, ld, ldx, ldy, lr;
  logic [1:0]           lc_code, conv_code;
  logic [W-1:0]         res_x, res_y;

  assign cur_x = xi;
  assign cur_y = yi;

  // Job length: line-circle always takes 4 vertices, other modes clamp n_vert to [3, MAX_VERT].
  always_comb begin
    job_len = n_vert;
    if (mode == MODE_LC)                  job_len = NW'(4);
    else if (n_vert < NW'(3))             job_len = NW'(3);
    else if (n_vert > NW'(MAX_VERT))      job_len = NW'(MAX_VERT);
  end

  // Cross-unit operand select: per-vertex terms while loading, wrap-around terms in CLOSE.
  always_comb begin
    ca_x1 = '0; ca_y1 = '0; ca_x2 = '0; ca_y2 = '0;
    cb_x1 = '0; cb_y1 = '0; cb_x2 = '0; cb_y2 = '0;
    if (state == ST_CLOSE) begin
      if (mode_r == MODE_CONV) begin
        ca_x1 = ext(p1x) - ext(p2x); ca_y1 = ext(p1y) - ext(p2y);
        ca_x2 = ext(v0x) - ext(p1x); ca_y2 = ext(v0y) - ext(p1y);
        cb_x1 = ext(v0x) - ext(p1x); cb_y1 = ext(v0y) - ext(p1y);
        cb_x2 = ext(v1x) - ext(v0x); cb_y2 = ext(v1y) - ext(v0y);
      end else if (mode_r == MODE_LC) begin
        ca_x1 = ext(v0x); ca_y1 = ext(v0y); ca_x2 = ext(v1x); ca_y2 = ext(v1y);
      end else begin
        ca_x1 = ext(p1x); ca_y1 = ext(p1y); ca_x2 = ext(v0x); ca_y2 = ext(v0y);
      end
    end else if (mode_r == MODE_CONV) begin
      ca_x1 = ext(p1x) - ext(p2x);   ca_y1 = ext(p1y) - ext(p2y);
      ca_x2 = ext(cur_x) - ext(p1x); ca_y2 = ext(cur_y) - ext(p1y);
    end else begin
      ca_x1 = ext(p1x); ca_y1 = ext(p1y); ca_x2 = ext(cur_x); ca_y2 = ext(cur_y);
    end
  end

  cc_cross2 #(.W(E)) u_cross_a (.x1(ca_x1), .y1(ca_y1), .x2(ca_x2), .y2(ca_y2), .cr(ca_cr));
  cc_cross2 #(.W(E)) u_cross_b (.x1(cb_x1), .y1(cb_y1), .x2(cb_x2), .y2(cb_y2), .cr(cb_cr));

  assign ca_neg = ca_cr[CW-1];
  assign ca_pos = !ca_cr[CW-1] && (ca_cr != '0);
  assign cb_neg = cb_cr[CW-1];
  assign cb_pos = !cb_cr[CW-1] && (cb_cr != '0);

  // Area: fold in the closing term, take |sum| and halve.
  assign acc_fin     = acc + AW'(ca_cr);
  assign acc_abs     = acc_fin[AW-1] ? -acc_fin : acc_fin;
  assign area        = acc_abs[2*W:1];
  assign unused_area = ^{acc_abs[AW-1:2*W+1], acc_abs[0]};

  // Line-circle: compare squared distance against squared radius, both scaled by (a^2+b^2).
  assign la  = LW'(v0y) - LW'(v1y);
  assign lb  = LW'(v1x) - LW'(v0x);
  assign lcc = LW'(ca_cr);
  assign lin = la * LW'(p2x) + lb * LW'(p2y) + lcc;
  assign ld  = lin * lin;
  assign ldx = LW'(p1x) - LW'(p2x);
  assign ldy = LW'(p1y) - LW'(p2y);
  assign lr  = (ldx * ldx + ldy * ldy) * (la * la + lb * lb);
  assign lc_code = (ld == lr) ? RES_TANGENT : ((ld < lr) ? RES_INTERSECT : RES_NONE);

  // Convexity: all nonzero turns must share a sign, and at least one must exist.
  assign pos_f = has_pos | ca_pos | cb_pos;
  assign neg_f = has_neg | ca_neg | cb_neg;
`ifdef CC_ORIENT_EN
  assign conv_code = (pos_f ^ neg_f) ? (pos_f ? 2'd1 : 2'd2) : 2'd0;
`else
  assign conv_code = {1'b0, pos_f ^ neg_f};
`endif

  // First result word, selected by the job mode.
  always_comb begin
    res_x = '0;
    res_y = '0;
    if (mode_r == MODE_AREA) begin
      res_x = area[2*W-1:W];
      res_y = area[W-1:0];
    end else if (mode_r == MODE_LC) begin
      res_y = W'(lc_code);
    end else if (mode_r == MODE_BBOX) begin
      res_x = xmin;
      res_y = ymin;
    end else begin
      res_y = W'(conv_code);
    end
  end

  // Job controller and incremental accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;  mode_r <= MODE_AREA; cnt <= '0; last_idx <= '0;
      v0x <= '0; v0y <= '0; v1x <= '0; v1y <= '0;
      p1x <= '0; p1y <= '0; p2x <= '0; p2y <= '0;
      xmin <= '0; ymin <= '0; xmax <= '0; ymax <= '0;
      acc <= '0; has_pos <= 1'b0; has_neg <= 1'b0; out_ph <= 1'b0;
      out_valid <= 1'b0; xo <= '0; yo <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          mode_r   <= mode;
          last_idx <= job_len - NW'(1);
          cnt      <= NW'(1);
          v0x <= cur_x; v0y <= cur_y; p1x <= cur_x; p1y <= cur_y; p2x <= '0; p2y <= '0;
          xmin <= cur_x; ymin <= cur_y; xmax <= cur_x; ymax <= cur_y;
          acc <= '0; has_pos <= 1'b0; has_neg <= 1'b0;
          state <= ST_LOAD;
        end
        ST_LOAD: if (in_valid) begin
          p2x <= p1x; p2y <= p1y; p1x <= cur_x; p1y <= cur_y;
          if (cnt == NW'(1)) begin
            v1x <= cur_x; v1y <= cur_y;
          end
          acc <= acc_fin;
          if (mode_r == MODE_CONV && cnt >= NW'(2)) begin
            has_pos <= has_pos | ca_pos;
            has_neg <= has_neg | ca_neg;
          end
          if (cur_x < xmin) xmin <= cur_x;
          if (cur_y < ymin) ymin <= cur_y;
          if (cur_x > xmax) xmax <= cur_x;
          if (cur_y > ymax) ymax <= cur_y;
          cnt <= cnt + NW'(1);
          if (cnt == last_idx) state <= ST_CLOSE;
        end
        ST_CLOSE: begin
          out_valid <= 1'b1;
          xo <= res_x;
          yo <= res_y;
          out_ph <= 1'b0;
          state <= ST_OUT;
        end
        default: begin
          if (mode_r == MODE_BBOX && !out_ph) begin
            xo <= xmax;
            yo <= ymax;
            out_ph <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            xo <= '0;
            yo <= '0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_poly_stream.sv
// tb_cc_poly_stream: randomized + directed jobs against a plain-arithmetic geometry model.
// Latency: expected result cycle is the last vertex cycle + 2 (+3 for bbox max word).
// Backpressure: none; jobs are spaced so each starts after out_valid has fallen.
`timescale 1ns/1ps
module tb_cc_poly_stream;

  localparam int W    = 8;
  localparam int MAXV = 8;
  localparam int NW   = $clog2(MAXV + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [NW-1:0] n_vert = '0;
  logic [W-1:0]  xi = '0, yi = '0;
  logic          out_valid;
  logic [W-1:0]  xo, yo;

  cc_poly_stream #(.COORD_W(W), .MAX_VERT(MAXV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .n_vert(n_vert),
    .xi(xi), .yi(yi), .out_valid(out_valid), .xo(xo), .yo(yo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vx[MAXV];
  int   vy[MAXV];

  function automatic void setp(input int i, input int x, input int y);
    vx[i] = x;
    vy[i] = y;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo, 0));
  endfunction

  function automatic int job_len(input int m, input int nv);
    if (m == 1) return 4;
    if (nv < 3) return 3;
    if (nv > MAXV) return MAXV;
    return nv;
  endfunction

  // Reference model: computes the expected result words straight from the vertex list.
  function automatic void push_exp(input int m, input int len, input int c, input string tag);
    exp_t   e;
    longint s, a, b, k, lin, d, r;
    int     mnx, mny, mxx, mxy, j, j2;
    bit     pos, neg;
    e.x = '0; e.y = '0; e.cyc = c; e.tag = tag;
    if (m == 0) begin
      s = 0;
      for (int i = 0; i < len; i++) begin
        j = (i + 1) % len;
        s += longint'(vx[i]) * vy[j] - longint'(vx[j]) * vy[i];
      end
      if (s < 0) s = -s;
      s = s / 2;
      e.x = s[2*W-1:W];
      e.y = s[W-1:0];
      sb.push_back(e);
    end else if (m == 1) begin
      a   = longint'(vy[0]) - vy[1];
      b   = longint'(vx[1]) - vx[0];
      k   = longint'(vx[0]) * vy[1] - longint'(vx[1]) * vy[0];
      lin = a * vx[2] + b * vy[2] + k;
      d   = lin * lin;
      r   = ((longint'(vx[3]) - vx[2]) ** 2 + (longint'(vy[3]) - vy[2]) ** 2) * (a * a + b * b);
      e.y = (d == r) ? 8'd2 : ((d < r) ? 8'd1 : 8'd0);
      sb.push_back(e);
    end else if (m == 2) begin
      mnx = vx[0]; mny = vy[0]; mxx = vx[0]; mxy = vy[0];
      for (int i = 1; i < len; i++) begin
        if (vx[i] < mnx) mnx = vx[i];
        if (vy[i] < mny) mny = vy[i];
        if (vx[i] > mxx) mxx = vx[i];
        if (vy[i] > mxy) mxy = vy[i];
      end
      e.x = mnx[W-1:0]; e.y = mny[W-1:0]; e.tag = {tag, "_min"};
      sb.push_back(e);
      e.x = mxx[W-1:0]; e.y = mxy[W-1:0]; e.cyc = c + 1; e.tag = {tag, "_max"};
      sb.push_back(e);
    end else begin
      pos = 1'b0; neg = 1'b0;
      for (int i = 0; i < len; i++) begin
        j  = (i + 1) % len;
        j2 = (i + 2) % len;
        s = (longint'(vx[j]) - vx[i]) * (longint'(vy[j2]) - vy[j])
          - (longint'(vy[j]) - vy[i]) * (longint'(vx[j2]) - vx[j]);
        if (s > 0) pos = 1'b1;
        if (s < 0) neg = 1'b1;
      end
`ifdef CC_ORIENT_EN
      e.y = (pos && !neg) ? 8'd1 : ((neg && !pos) ? 8'd2 : 8'd0);
`else
      e.y = (pos != neg) ? 8'd1 : 8'd0;
`endif
      sb.push_back(e);
    end
  endfunction

  // Drive one job; abort_k >= 0 pulses reset instead of sending vertex abort_k.
  task automatic run_job(input int m, input int nv, input int abort_k, input string tag);
    int len;
    len = job_len(m, nv);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (abort_k >= 0 && i == abort_k) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || xo !== '0 || yo !== '0) begin
          miscompares++;
          $display("FAIL %s_reset: got out_valid=%b xo=%0h yo=%0h, required 0 0 0", tag, out_valid, xo, yo);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      in_valid = 1'b1;
      mode     = m[1:0];
      n_vert   = nv[NW-1:0];
      xi       = vx[i][W-1:0];
      yi       = vy[i][W-1:0];
      if (i == len - 1) push_exp(m, len, cyc + 2, tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    xi = '0;
    yi = '0;
    repeat (2 + $urandom_range(2, 0)) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard whenever a result appears, checks idle outputs otherwise.
  exp_t got_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_result: got xo=%0h yo=%0h at cycle %0d, required no result", xo, yo, cyc);
        end else begin
          got_e = sb.pop_front();
          vectors++;
          if (xo !== got_e.x || yo !== got_e.y || cyc != got_e.cyc) begin
            miscompares++;
            $display("FAIL %s: got xo=%0h yo=%0h at cycle %0d, required xo=%0h yo=%0h at cycle %0d",
                     got_e.tag, xo, yo, cyc, got_e.x, got_e.y, got_e.cyc);
          end
        end
      end else if (out_valid !== 1'b0 || xo !== '0 || yo !== '0) begin
        miscompares++;
        $display("FAIL idle_outputs: got out_valid=%b xo=%0h yo=%0h at cycle %0d, required 0 0 0",
                 out_valid, xo, yo, cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int m, nv, len, rng;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || xo !== '0 || yo !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got out_valid=%b xo=%0h yo=%0h, required 0 0 0", out_valid, xo, yo);
    end
    rst_n = 1'b1;
    @(posedge clk);

    // Area cases
    setp(0, 0, 0); setp(1, 4, 0); setp(2, 4, 4); setp(3, 0, 4);
    run_job(0, 4, -1, "area_square");
    setp(0, 0, 0); setp(1, 3, 0); setp(2, 0, 3);
    run_job(0, 3, -1, "area_tri_ccw");
    setp(0, 0, 0); setp(1, 0, 3); setp(2, 3, 0);
    run_job(0, 3, -1, "area_tri_cw");
    setp(0, -128, -128); setp(1, 127, -128); setp(2, 127, 127); setp(3, -128, 127);
    run_job(0, 4, -1, "area_full_range");
    setp(0, 1, 1); setp(1, 1, 1); setp(2, 6, 1); setp(3, 6, 5);
    run_job(0, 1, -1, "area_dup_nv_low");

    // Line-circle cases
    setp(0, 0, 0); setp(1, 1, 0); setp(2, 0, 2); setp(3, 0, 0);
    run_job(1, 0, -1, "lc_tangent");
    setp(2, 0, 1); setp(3, 0, 3);
    run_job(1, 9, -1, "lc_intersect");
    setp(2, 0, 5); setp(3, 0, 6);
    run_job(1, 3, -1, "lc_none");

    // Bounding box
    setp(0, 3, -7); setp(1, 10, 2); setp(2, -4, 9); setp(3, 0, 0); setp(4, 5, 5);
    run_job(2, 5, -1, "bbox5");

    // Convexity
    setp(0, 0, 0); setp(1, 4, 0); setp(2, 4, 4); setp(3, 0, 4);
    run_job(3, 4, -1, "conv_square_ccw");
    setp(0, 0, 0); setp(1, 0, 4); setp(2, 4, 4); setp(3, 4, 0);
    run_job(3, 4, -1, "conv_square_cw");
    setp(0, 0, 0); setp(1, 4, 2); setp(2, 0, 4); setp(3, 2, 2);
    run_job(3, 4, -1, "conv_arrow");
    setp(0, 0, 0); setp(1, 2, 2); setp(2, 5, 5);
    run_job(3, 3, -1, "conv_collinear");

    // Reset mid-load, then the same job must come out clean
    setp(0, 0, 0); setp(1, 4, 0); setp(2, 4, 4); setp(3, 0, 4);
    run_job(0, 4, 2, "abort_area");
    run_job(0, 4, -1, "after_abort");

    // Oversized count clamps to MAX_VERT
    for (int i = 0; i < MAXV; i++) setp(i, rnd(-128, 127), rnd(-128, 127));
    run_job(0, 15, -1, "area_nv_clamp");

    // Randomized back-to-back jobs
    for (int t = 0; t < 40; t++) begin
      m   = rnd(0, 3);
      nv  = rnd(0, 15);
      len = job_len(m, nv);
      rng = (m == 1 && t[0]) ? 3 : 127;
      for (int i = 0; i < len; i++) setp(i, rnd(-rng - 1, rng), rnd(-rng - 1, rng));
      run_job(m, nv, -1, $sformatf("rand%0d_m%0d", t, m));
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
